// File: rtl/dro_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dro_writer_pkg
//  Description : Shared types and helpers for the DRO pulse writer.
//                - dro_state_e : writer FSM states (one slot = DATA, SETUP,
//                                CLOCK, HOLD; IDLE between words)
//                - slot_len()  : cycles per bit slot
//                - rb_depth()  : readback checks that can be in flight
//  Revision    : 1.0  initial release
// ============================================================================
package dro_writer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        SETUP = 3'd2,
        CLOCK = 3'd3,
        HOLD  = 3'd4
    } dro_state_e;

    // The clk pulse starts T_SETUP after the d pulse; the slot then lasts
    // until both the hold time and the clk pulse itself have elapsed.
    function automatic int slot_len(input int t_setup, input int t_hold, input int pulse_w);
        return t_setup + ((t_hold > pulse_w) ? t_hold : pulse_w);
    endfunction

    // ceil((delay+1)/slot) + 1 pending checks cover a readback delay that
    // spills over into later slots.
    function automatic int rb_depth(input int delay, input int slot);
        return ((delay + slot) / slot) + 1;
    endfunction

    // Readback depth for the default parameter set.
    localparam int RB_DEPTH_DEFAULT = rb_depth(9, slot_len(8, 3, 2));

endpackage : dro_writer_pkg
`default_nettype wire

// File: rtl/dro_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dro_slot_timer
//  Description : Offset counter 0..SLOT-1 for one bit slot. Reports the end
//                of the current slot plus the pulse windows of the offset
//                that will be current in the next cycle, so the writer can
//                drive registered pulse outputs with no extra latency.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_start           word accepted, next offset is 0
//                i_adv             slot in progress, advance/wrap offset
//                o_slot_end        current offset is SLOT-1
//                o_clk_rise        current offset is T_SETUP
//                o_d_win_nx        next offset in 0..PULSE_W-1
//                o_pre_clk_nx      next offset below T_SETUP
//                o_clk_win_nx      next offset in T_SETUP..T_SETUP+PULSE_W-1
//  Revision    : 1.0  initial release
// ============================================================================
module dro_slot_timer
    import dro_writer_pkg::*;
#(
    parameter int SLOT    = slot_len(8, 3, 2),
    parameter int T_SETUP = 8,
    parameter int PULSE_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_adv,
    output logic o_slot_end,
    output logic o_clk_rise,
    output logic o_d_win_nx,
    output logic o_pre_clk_nx,
    output logic o_clk_win_nx
);

    localparam int OFF_W = (SLOT > 1) ? $clog2(SLOT) : 1;

    // Window limits are stored as last-included offsets so that every value
    // fits in OFF_W bits even when the clk window ends exactly at SLOT.
    localparam logic [OFF_W-1:0] C_OFF_LAST  = OFF_W'(SLOT - 1);
    localparam logic [OFF_W-1:0] C_D_LAST    = OFF_W'(PULSE_W - 1);
    localparam logic [OFF_W-1:0] C_CLK_FIRST = OFF_W'(T_SETUP);
    localparam logic [OFF_W-1:0] C_CLK_LAST  = OFF_W'(T_SETUP + PULSE_W - 1);

    logic [OFF_W-1:0] off_q;
    logic [OFF_W-1:0] off_d;
    logic             w_slot_end;

    assign w_slot_end = (off_q == C_OFF_LAST);

    // Outside a slot the counter rests at 0, which is also the first offset
    // of a freshly started slot.
    always_comb begin
        off_d = '0;
        if (!i_start && i_adv && !w_slot_end) begin
            off_d = off_q + OFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign o_slot_end   = w_slot_end;
    assign o_clk_rise   = (off_q == C_CLK_FIRST);
    assign o_d_win_nx   = (off_d <= C_D_LAST);
    assign o_pre_clk_nx = (off_d <  C_CLK_FIRST);
    assign o_clk_win_nx = (off_d >= C_CLK_FIRST) && (off_d <= C_CLK_LAST);

endmodule : dro_slot_timer
`default_nettype wire

// File: rtl/dro_pulse_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dro_pulse_writer
//  Description : Serializes a parallel word, LSB first, into d/clk pulse
//                pairs for an RSFQ DRO chain, one bit per slot of
//                T_SETUP + max(T_HOLD, PULSE_W) cycles. A 1 bit emits a d
//                pulse at the start of its slot; every slot emits a clk pulse
//                T_SETUP cycles later.
//  Build option: DRO_WRITER_READBACK_EN - compare dro_out, sampled DELAY
//                cycles after each clk pulse rise, with the bit written in
//                that slot (err strobe, saturating err_count). Without it
//                dro_out is ignored and err/err_count stay 0.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                in_valid/in_ready   word handshake (ready only when idle)
//                in_data[WIDTH]      word, captured at accept
//                d_pulse, clk_pulse  pulses to the DRO d and clk inputs
//                busy                word in flight
//                done                1-cycle strobe after the last slot
//                dro_out             DRO output for readback
//                err, err_count[8]   readback mismatch strobe / count
//  Revision    : 1.0  initial release
// ============================================================================
module dro_pulse_writer
    import dro_writer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int T_SETUP = 8,
    parameter int T_HOLD  = 3,
    parameter int PULSE_W = 2,
    parameter int DELAY   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             d_pulse,
    output logic             clk_pulse,
    output logic             busy,
    output logic             done,
    input  logic             dro_out,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam int SLOT  = slot_len(T_SETUP, T_HOLD, PULSE_W);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (T_SETUP < PULSE_W) begin : g_bad_setup
        $error("dro_pulse_writer: T_SETUP (%0d) must be >= PULSE_W (%0d)", T_SETUP, PULSE_W);
    end
    if (WIDTH < 1 || PULSE_W < 1 || T_HOLD < 0) begin : g_bad_sizes
        $error("dro_pulse_writer: need WIDTH >= 1, PULSE_W >= 1, T_HOLD >= 0");
    end

    // ------------------------------------------------------------------
    // Slot timer
    // ------------------------------------------------------------------
    dro_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic             d_pulse_q, d_pulse_d;
    logic             clk_pulse_q, clk_pulse_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic w_accept;
    logic w_active;
    logic w_last;
    logic w_slot_end;
    logic w_clk_rise;
    logic w_d_win_nx;
    logic w_pre_clk_nx;
    logic w_clk_win_nx;

    assign w_accept = in_valid & in_ready_q;
    assign w_active = (state_q != IDLE);
    assign w_last   = w_active & w_slot_end & (idx_q == C_IDX_LAST);

    dro_slot_timer #(
        .SLOT    (SLOT),
        .T_SETUP (T_SETUP),
        .PULSE_W (PULSE_W)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_accept),
        .i_adv        (w_active),
        .o_slot_end   (w_slot_end),
        .o_clk_rise   (w_clk_rise),
        .o_d_win_nx   (w_d_win_nx),
        .o_pre_clk_nx (w_pre_clk_nx),
        .o_clk_win_nx (w_clk_win_nx)
    );

    // ------------------------------------------------------------------
    // Writer FSM. Every output is registered from its next-cycle value so
    // the pulses leave the block straight from flops.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = w_accept | (w_active & ~w_last);

        // Current bit is always data_q[0]; shift at each slot boundary.
        data_d = data_q;
        if (w_accept) begin
            data_d = in_data;
        end else if (w_active && w_slot_end) begin
            data_d = data_q >> 1;
        end

        idx_d = idx_q;
        if (w_accept || w_last) begin
            idx_d = '0;
        end else if (w_active && w_slot_end) begin
            idx_d = idx_q + IDX_W'(1);
        end

        // State tracks which part of the slot the next offset falls in.
        // SETUP or HOLD are skipped when they have zero length.
        if (!busy_d) begin
            state_d = IDLE;
        end else if (w_d_win_nx) begin
            state_d = DATA;
        end else if (w_pre_clk_nx) begin
            state_d = SETUP;
        end else if (w_clk_win_nx) begin
            state_d = CLOCK;
        end else begin
            state_d = HOLD;
        end

        d_pulse_d   = busy_d & w_d_win_nx & data_d[0];
        clk_pulse_d = busy_d & w_clk_win_nx;
        done_d      = w_last;
        in_ready_d  = ~busy_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            d_pulse_q   <= 1'b0;
            clk_pulse_q <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            d_pulse_q   <= d_pulse_d;
            clk_pulse_q <= clk_pulse_d;
            done_q      <= done_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign d_pulse   = d_pulse_q;
    assign clk_pulse = clk_pulse_q;
    assign done      = done_q;

    // ------------------------------------------------------------------
    // Readback checker
    // ------------------------------------------------------------------
`ifdef DRO_WRITER_READBACK_EN
    localparam int RB_DEPTH = rb_depth(DELAY, SLOT);
    localparam int CNT_W    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    logic [RB_DEPTH-1:0] rb_vld_q, rb_vld_d;
    logic [RB_DEPTH-1:0] rb_bit_q, rb_bit_d;
    logic [CNT_W-1:0]    rb_cnt_q [RB_DEPTH];
    logic [CNT_W-1:0]    rb_cnt_d [RB_DEPTH];
    logic                err_q, err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                w_mism;
    logic                w_placed;
    logic                w_push;

    // A check is queued on the first clk-pulse cycle of each slot, holding
    // the bit just written and the cycles left until dro_out is sampled.
    assign w_push = w_active & w_clk_rise;

    always_comb begin
        rb_vld_d = rb_vld_q;
        rb_bit_d = rb_bit_q;
        rb_cnt_d = rb_cnt_q;
        w_mism   = 1'b0;
        w_placed = 1'b0;

        for (int i = 0; i < RB_DEPTH; i++) begin
            if (rb_vld_q[i]) begin
                if (rb_cnt_q[i] == '0) begin
                    rb_vld_d[i] = 1'b0;
                    if (rb_bit_q[i] != dro_out) begin
                        w_mism = 1'b1;
                    end
                end else begin
                    rb_cnt_d[i] = rb_cnt_q[i] - CNT_W'(1);
                end
            end
        end

        if (w_push) begin
            if (DELAY == 0) begin
                // Zero delay: the sample point is this very cycle.
                if (data_q[0] != dro_out) begin
                    w_mism = 1'b1;
                end
            end else begin
                // Entry retired this cycle may be reused immediately.
                for (int i = 0; i < RB_DEPTH; i++) begin
                    if (!w_placed && !rb_vld_d[i]) begin
                        rb_vld_d[i] = 1'b1;
                        rb_bit_d[i] = data_q[0];
                        rb_cnt_d[i] = CNT_W'(DELAY - 1);
                        w_placed    = 1'b1;
                    end
                end
            end
        end

        err_d       = w_mism;
        err_count_d = err_count_q;
        if (w_mism && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_vld_q    <= '0;
            rb_bit_q    <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < RB_DEPTH; i++) begin
                rb_cnt_q[i] <= '0;
            end
        end else begin
            rb_vld_q    <= rb_vld_d;
            rb_bit_q    <= rb_bit_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            for (int i = 0; i < RB_DEPTH; i++) begin
                rb_cnt_q[i] <= rb_cnt_d[i];
            end
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    // Readback absent: dro_out and DELAY are intentionally unused.
    logic w_unused_readback;
    assign w_unused_readback = dro_out ^ DELAY[0];

    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule : dro_pulse_writer
`default_nettype wire

// File: tb/tb_dro_pulse_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dro_pulse_writer
//  Description : Directed self-checking bench for dro_pulse_writer (default
//                parameters, SLOT=11) plus a WIDTH=1/T_HOLD=0/PULSE_W=1
//                instance (SLOT=9). A small DRO model feeds dro_out with a
//                9-cycle clk-to-out delay; force_zero pins dro_out low.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dro_pulse_writer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       d_pulse;
    logic       clk_pulse;
    logic       busy;
    logic       done;
    logic       dro_out;
    logic       err;
    logic [7:0] err_count;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [0:0] s_in_data;
    logic       s_d_pulse;
    logic       s_clk_pulse;
    logic       s_busy;
    logic       s_done;
    logic       s_err;
    logic [7:0] s_err_count;

    dro_pulse_writer u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .d_pulse   (d_pulse),
        .clk_pulse (clk_pulse),
        .busy      (busy),
        .done      (done),
        .dro_out   (dro_out),
        .err       (err),
        .err_count (err_count)
    );

    dro_pulse_writer #(
        .WIDTH   (1),
        .T_SETUP (8),
        .T_HOLD  (0),
        .PULSE_W (1),
        .DELAY   (9)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .d_pulse   (s_d_pulse),
        .clk_pulse (s_clk_pulse),
        .busy      (s_busy),
        .done      (s_done),
        .dro_out   (1'b0),
        .err       (s_err),
        .err_count (s_err_count)
    );

    // DRO model: d pulse stores a 1, clk rise reads it out 9 cycles later.
    logic       force_zero;
    logic       dro_stored;
    logic       prev_clk;
    logic [8:0] pipe;

    always @(posedge clk) begin
        if (rst) begin
            dro_stored <= 1'b0;
            prev_clk   <= 1'b0;
            pipe       <= '0;
        end else begin
            prev_clk <= clk_pulse;
            pipe     <= {pipe[7:0], clk_pulse & ~prev_clk & dro_stored};
            if (clk_pulse && !prev_clk) begin
                dro_stored <= 1'b0;
            end else if (d_pulse) begin
                dro_stored <= 1'b1;
            end
        end
    end

    assign dro_out = force_zero ? 1'b0 : pipe[8];

    int checks = 0;
    int errors = 0;

    logic [255:0] t_d, t_c, t_dn, t_b, t_r, t_e;
    logic [255:0] ev;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected d pulses: bit k set -> cycles base+1+k*slot .. +pw-1.
    function automatic logic [255:0] exp_d(input logic [7:0] w, input int base,
                                           input int width, input int slot, input int pw);
        logic [255:0] v = '0;
        for (int k = 0; k < width; k++) begin
            if (w[k]) begin
                for (int o = 0; o < pw; o++) v[base + 1 + k * slot + o] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [255:0] exp_c(input int base, input int width, input int slot,
                                           input int tsu, input int pw);
        logic [255:0] v = '0;
        for (int k = 0; k < width; k++) begin
            for (int o = 0; o < pw; o++) v[base + 1 + k * slot + tsu + o] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [255:0] range_vec(input int lo, input int hi);
        logic [255:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] bit_vec(input int i);
        logic [255:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Offer w0 at relative cycle 0 and trace ncyc cycles. Optional: keep
    // in_valid high with changing data, offer w1 at second_at, rst at rst_at.
    task automatic run_trace(input int ncyc, input logic [7:0] w0, input bit hold,
                             input int second_at, input logic [7:0] w1, input int rst_at);
        t_d = '0; t_c = '0; t_dn = '0; t_b = '0; t_r = '0; t_e = '0;
        in_valid = 1'b1;
        in_data  = w0;
        for (int r = 0; r < ncyc; r++) begin
            @(negedge clk);
            t_d[r]  = d_pulse;
            t_c[r]  = clk_pulse;
            t_dn[r] = done;
            t_b[r]  = busy;
            t_r[r]  = in_ready;
            t_e[r]  = err;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (hold && r < 87) begin
                in_valid = 1'b1;
                in_data  = 8'h33 + 8'(r);
            end
            if (r == second_at - 1) begin
                in_valid = 1'b1;
                in_data  = w1;
            end
            rst = (r == rst_at - 1);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        force_zero = 1'b0;
        ev         = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {in_ready, busy, d_pulse, clk_pulse, done, err}, 6'b100000);
        check("reset_err_count", err_count, 8'd0);
        check("reset_small_ready", {s_in_ready, s_busy, s_done}, 3'b100);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- 0xA5 ----------------
        run_trace(90, 8'hA5, 1'b0, -1, 8'h00, -1);
        check("a5_first_d", t_d[3:0], 4'b0110);
        check("a5_slot2_d", t_d[25:22], 4'b0110);
        check("a5_first_clk", t_c[11:8], 4'b0110);
        check("a5_d_all", t_d, exp_d(8'hA5, 0, 8, 11, 2));
        check("a5_clk_all", t_c, exp_c(0, 8, 11, 8, 2));
        check("a5_done", t_dn, bit_vec(89));
        check("a5_busy", t_b, range_vec(1, 88));
        check("a5_ready", t_r, bit_vec(0) | bit_vec(89));

        // ---------------- 0x00 then 0xFF back-to-back ----------------
        run_trace(180, 8'h00, 1'b0, 89, 8'hFF, -1);
        check("b2b_no_d_first", t_d[88:0], 89'd0);
        check("b2b_d_all", t_d, exp_d(8'hFF, 89, 8, 11, 2));
        check("b2b_done", t_dn, bit_vec(89) | bit_vec(178));
        check("b2b_accept_in_done", {t_r[90], t_b[90]}, 2'b01);

        // ---------------- in_valid held with changing data ----------------
        run_trace(90, 8'h5A, 1'b1, -1, 8'h00, -1);
        check("hold_d_all", t_d, exp_d(8'h5A, 0, 8, 11, 2));
        check("hold_done", t_dn, bit_vec(89));
        check("hold_busy", t_b, range_vec(1, 88));

        // ---------------- rst at cycle 30 of a word ----------------
        run_trace(60, 8'hFF, 1'b0, -1, 8'h00, 30);
        ev = exp_d(8'hFF, 0, 8, 11, 2);
        check("rst_pre_d", t_d[30:0], ev[30:0]);
        check("rst_busy_c30", t_b[30], 1'b1);
        check("rst_outs_c31", {t_r[31], t_b[31], t_d[31], t_c[31], t_dn[31]}, 5'b10000);
        check("rst_no_d_after", t_d[59:31], 29'd0);
        check("rst_no_clk_after", t_c[59:31], 29'd0);
        check("rst_no_done", t_dn, 256'd0);

        // ---------------- WIDTH=1, T_HOLD=0, PULSE_W=1 (SLOT=9) ----------------
        t_d = '0; t_c = '0; t_dn = '0; t_b = '0; t_r = '0;
        s_in_valid = 1'b1;
        s_in_data  = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            t_d[r]  = s_d_pulse;
            t_c[r]  = s_clk_pulse;
            t_dn[r] = s_done;
            t_b[r]  = s_busy;
            t_r[r]  = s_in_ready;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
        end
        check("small_d", t_d, bit_vec(1));
        check("small_clk", t_c, bit_vec(9));
        check("small_done", t_dn, bit_vec(10));
        check("small_busy", t_b, range_vec(1, 9));
        check("small_ready", t_r, bit_vec(0) | bit_vec(10) | bit_vec(11));

        // ---------------- readback ----------------
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef DRO_WRITER_READBACK_EN
        run_trace(100, 8'h3C, 1'b0, -1, 8'h00, -1);
        check("rb_ok_err", t_e, 256'd0);
        check("rb_ok_count", err_count, 8'd0);
        force_zero = 1'b1;
        run_trace(100, 8'h3C, 1'b0, -1, 8'h00, -1);
        check("rb_zero_err", t_e, bit_vec(41) | bit_vec(52) | bit_vec(63) | bit_vec(74));
        check("rb_zero_count", err_count, 8'd4);
        force_zero = 1'b0;
`else
        force_zero = 1'b1;
        run_trace(100, 8'h3C, 1'b0, -1, 8'h00, -1);
        check("norb_err", t_e, 256'd0);
        check("norb_count", err_count, 8'd0);
        force_zero = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dro_pulse_writer
`default_nettype wire
